ipv4_pkt_builder: RTL and testbench
===================================

Name: ipv4_pkt_builder

Overview:
TX-side counterpart of the RX IPv4 router. Accepts UDP and ICMP payload streams from first-word-fall-through sources, arbitrates between them at packet boundaries, and builds a 20-byte IPv4 header (no options) with a computed header checksum. It emits header + payload as a byte stream to the Ethernet frame builder. Sits between the UDP/ICMP TX engines and the eth frame TX path.

Parameters:
SRC_IP_ADDR, 32'h0A000001, IPv4 source address placed in every header
IPV4_TTL, 8'd64, TTL field value
DF_EN, 1, 1 = set Don't-Fragment flag (flags/frag word 0x4000), 0 = 0x0000
PAYLOAD_MAX_BYTES, 1480, largest legal payload; larger or zero lengths are dropped

Ports:
i_txmac_clk  in  1  clock
i_txmac_arst_n  in  1  asynchronous active-low reset
i_udp_pkt_byte  in  8  UDP payload byte (FWFT)
i_udp_pkt_byte_vld  in  1  byte valid
i_udp_pkt_last_byte  in  1  last payload byte of packet
i_udp_pkt_len  in  16  payload byte count, stable while first byte is presented
i_udp_dst_ip  in  32  destination IP, stable while first byte is presented
o_udp_pkt_byte_rd  out  1  read/pop strobe to UDP source
i_icmp_pkt_byte, i_icmp_pkt_byte_vld, i_icmp_pkt_last_byte, i_icmp_pkt_len, i_icmp_dst_ip, o_icmp_pkt_byte_rd  -  same as UDP set, for ICMP
o_ipv4_pkt_byte  out  8  IPv4 packet byte
o_ipv4_pkt_byte_vld  out  1  output byte valid (FWFT style)
o_ipv4_pkt_last_byte  out  1  last byte of IPv4 packet
i_ipv4_pkt_byte_rd  in  1  downstream consumes byte when rd & vld
o_len_mismatch  out  1  one-clock pulse: input last_byte count != declared length
o_pkt_dropped  out  1  one-clock pulse: packet with length 0 or > PAYLOAD_MAX_BYTES discarded

Behaviour:
- Reset (async assert, sync deassert assumed upstream): all outputs 0, FSM IDLE, ident counter 0, round-robin pointer = UDP.
- Input read: byte consumed when o_x_pkt_byte_rd & i_x_pkt_byte_vld. rd is asserted only in SEND_PAYLOAD/DROP for the selected source; never for the unselected source.
- Output: single register stage. vld holds with byte/last stable until i_ipv4_pkt_byte_rd. Stage reloads the same cycle it is consumed (full throughput, 1 byte/clk).
- FSM:
  IDLE: if any source vld -> ARB.
  ARB: pick source. Round-robin: prefer source opposite the last served; if only one is vld, take it. Latch len, dst_ip, proto (UDP 0x11, ICMP 0x01). If len==0 or len>PAYLOAD_MAX_BYTES -> pulse o_pkt_dropped, go DROP; else -> CALC.
  CALC: accumulate 10 16-bit words sequentially (one per clock): 0x4500, len+20, ident, flags, {TTL,proto}, 0x0000, src hi/lo, dst hi/lo, into a 20-bit sum. Then fold carries twice (2 clocks), invert -> checksum. 12 clocks total -> SEND_HDR.
  SEND_HDR: emit 20 header bytes, big-endian, in field order; byte index advances only on output-stage load.
  SEND_PAYLOAD: forward bytes; count payload bytes. On input last_byte: output last=1. If count != latched len, pulse o_len_mismatch (packet still terminated at input last). Increment ident (16-bit wrap 0xFFFF->0x0000), update RR pointer -> IDLE.
  DROP: read and discard until last_byte consumed -> IDLE. Ident unchanged.
- Total length field = len+20, 16-bit.
- Source vld deasserting mid-payload: stall, no bubbles flagged, no error.
- Downstream stall during SEND_HDR/SEND_PAYLOAD: all state frozen, no input reads.
- Reset mid-packet: output cleared immediately; partially-read input packet is upstream's responsibility.

Optional Feature:
IPV4_PKT_BUILDER_ICMP_PRIO_EN: when defined, ARB uses fixed priority with ICMP over UDP (RR pointer removed). When undefined, round-robin as above.

Test Plan:
- Single UDP pkt, len=8, dst 0x0A000002, ident 0 -> output 28 bytes: 45 00 00 1C 00 00 40 00 40 11 26 CF 0A 00 00 01 0A 00 00 02 + 8 payload bytes, last on byte 28; next pkt ident=1.
- UDP and ICMP both vld continuously, 3 pkts each -> output order U,I,U,I,U,I (RR); with ICMP_PRIO_EN -> all 3 ICMP first.
- UDP len=1500 -> o_pkt_dropped pulse, 1500 input bytes read, no output, ident unchanged; len=0 same.
- Declared len=10, last_byte on 7th byte -> 27 output bytes, last set on 27th, o_len_mismatch pulse once.
- Random i_ipv4_pkt_byte_rd (50%) and random source vld gaps on 64-byte pkts -> byte-exact stream, no loss or duplication.
- Ident at 0xFFFF -> packet carries 0xFFFF, next carries 0x0000 with correct checksum; assert reset mid-header -> all outputs 0 same cycle, clean restart.

Source files
------------

// File: rtl/ipv4_pkt_builder.sv
// ----------------------------------------------------------------------------
// ipv4_pkt_builder
//
// TX-side IPv4 packet builder.
//  - Takes UDP and ICMP payload streams from first-word-fall-through sources.
//  - Arbitrates between the two sources at packet boundaries.
//  - Builds a 20-byte IPv4 header (no options) with a computed header checksum.
//  - Emits header followed by payload as a byte stream towards the Ethernet
//    frame builder.
//
// Optional build macro:
//   IPV4_PKT_BUILDER_ICMP_PRIO_EN - when defined, ICMP has fixed priority over
//                                   UDP; otherwise the sources are served
//                                   round-robin.
//
// Ports:
//   i_txmac_clk, i_txmac_arst_n      clock, asynchronous active-low reset
//   i_udp_*  / o_udp_pkt_byte_rd     UDP payload source (FWFT) and its pop strobe
//   i_icmp_* / o_icmp_pkt_byte_rd    ICMP payload source (FWFT) and its pop strobe
//   o_ipv4_pkt_byte/_vld/_last_byte  output byte stream (single register stage)
//   i_ipv4_pkt_byte_rd               downstream consumes a byte when rd & vld
//   o_len_mismatch                   pulse: received byte count != declared length
//   o_pkt_dropped                    pulse: packet with illegal length discarded
// ----------------------------------------------------------------------------
module ipv4_pkt_builder #(
    parameter logic [31:0] SRC_IP_ADDR       = 32'h0A000001,
    parameter logic [7:0]  IPV4_TTL          = 8'd64,
    parameter bit          DF_EN             = 1'b1,
    parameter int          PAYLOAD_MAX_BYTES = 1480
) (
    input  logic        i_txmac_clk,
    input  logic        i_txmac_arst_n,

    input  logic [7:0]  i_udp_pkt_byte,
    input  logic        i_udp_pkt_byte_vld,
    input  logic        i_udp_pkt_last_byte,
    input  logic [15:0] i_udp_pkt_len,
    input  logic [31:0] i_udp_dst_ip,
    output logic        o_udp_pkt_byte_rd,

    input  logic [7:0]  i_icmp_pkt_byte,
    input  logic        i_icmp_pkt_byte_vld,
    input  logic        i_icmp_pkt_last_byte,
    input  logic [15:0] i_icmp_pkt_len,
    input  logic [31:0] i_icmp_dst_ip,
    output logic        o_icmp_pkt_byte_rd,

    output logic [7:0]  o_ipv4_pkt_byte,
    output logic        o_ipv4_pkt_byte_vld,
    output logic        o_ipv4_pkt_last_byte,
    input  logic        i_ipv4_pkt_byte_rd,

    output logic        o_len_mismatch,
    output logic        o_pkt_dropped
);

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        CALC,
        SEND_HDR,
        SEND_PAYLOAD,
        DROP
    } state_t;

    localparam logic [15:0] MAX_LEN    = 16'(PAYLOAD_MAX_BYTES);
    localparam logic [15:0] FLAGS_WORD = DF_EN ? 16'h4000 : 16'h0000;
    localparam logic [7:0]  PROTO_UDP  = 8'h11;
    localparam logic [7:0]  PROTO_ICMP = 8'h01;

    state_t      state;
    state_t      state_next;

    // Output register stage
    logic [7:0]  out_byte;
    logic        out_vld;
    logic        out_last;

    // Per-packet context latched in ARB
    logic        sel_icmp;
    logic [15:0] len_q;
    logic [31:0] dst_q;
    logic [7:0]  proto_q;

    // Checksum / sequencing
    logic [19:0] sum_q;
    logic [3:0]  calc_cnt;
    logic [4:0]  hdr_idx;
    logic [15:0] pay_cnt;
    logic [15:0] ident_q;

    logic        len_mismatch_q;
    logic        pkt_dropped_q;

`ifndef IPV4_PKT_BUILDER_ICMP_PRIO_EN
    // 1 = ICMP is preferred at the next arbitration (opposite of last served)
    logic        rr_prefer_icmp;
`endif

    // Selected source view
    logic        src_vld;
    logic        src_last;
    logic [7:0]  src_byte;

    assign src_vld  = sel_icmp ? i_icmp_pkt_byte_vld  : i_udp_pkt_byte_vld;
    assign src_last = sel_icmp ? i_icmp_pkt_last_byte : i_udp_pkt_last_byte;
    assign src_byte = sel_icmp ? i_icmp_pkt_byte      : i_udp_pkt_byte;

    // Arbitration decision, only meaningful while in ARB
    logic        any_vld;
    logic        pick_icmp;
    logic [15:0] pick_len;
    logic        pick_len_bad;

    assign any_vld = i_udp_pkt_byte_vld || i_icmp_pkt_byte_vld;

    always_comb begin
`ifdef IPV4_PKT_BUILDER_ICMP_PRIO_EN
        pick_icmp = i_icmp_pkt_byte_vld;
`else
        pick_icmp = i_icmp_pkt_byte_vld && (!i_udp_pkt_byte_vld || rr_prefer_icmp);
`endif
    end

    assign pick_len     = pick_icmp ? i_icmp_pkt_len : i_udp_pkt_len;
    assign pick_len_bad = (pick_len == 16'd0) || (pick_len > MAX_LEN);

    // Header word mux, shared by the checksum accumulator (CALC) and the
    // byte serialiser (SEND_HDR). The checksum word reads as zero while it
    // is being computed.
    logic [3:0]  word_sel;
    logic [15:0] word_val;
    logic [15:0] total_len;
    logic [15:0] csum;

    assign total_len = len_q + 16'd20;
    assign csum      = ~sum_q[15:0];
    assign word_sel  = (state == CALC) ? calc_cnt : hdr_idx[4:1];

    always_comb begin
        word_val = 16'h0000;
        case (word_sel)
            4'd0:    word_val = 16'h4500;
            4'd1:    word_val = total_len;
            4'd2:    word_val = ident_q;
            4'd3:    word_val = FLAGS_WORD;
            4'd4:    word_val = {IPV4_TTL, proto_q};
            4'd5:    word_val = (state == CALC) ? 16'h0000 : csum;
            4'd6:    word_val = SRC_IP_ADDR[31:16];
            4'd7:    word_val = SRC_IP_ADDR[15:0];
            4'd8:    word_val = dst_q[31:16];
            4'd9:    word_val = dst_q[15:0];
            default: word_val = 16'h0000;
        endcase
    end

    // The output stage can take a new byte when empty or emptying this cycle
    logic        stage_free;
    assign stage_free = !out_vld || i_ipv4_pkt_byte_rd;

    logic        src_rd;
    logic        take;
    logic        load;
    logic [7:0]  load_byte;
    logic        load_last;

    // Next-state and per-cycle control strobes
    always_comb begin
        state_next = state;
        src_rd     = 1'b0;
        take       = 1'b0;
        load       = 1'b0;
        load_byte  = 8'h00;
        load_last  = 1'b0;
        case (state)
            IDLE: begin
                if (any_vld) state_next = ARB;
            end
            ARB: begin
                // A source may have gone empty since IDLE; just retry later
                if (!any_vld)          state_next = IDLE;
                else if (pick_len_bad) state_next = DROP;
                else                   state_next = CALC;
            end
            CALC: begin
                if (calc_cnt == 4'd11) state_next = SEND_HDR;
            end
            SEND_HDR: begin
                if (stage_free) begin
                    load      = 1'b1;
                    load_byte = hdr_idx[0] ? word_val[7:0] : word_val[15:8];
                    if (hdr_idx == 5'd19) state_next = SEND_PAYLOAD;
                end
            end
            SEND_PAYLOAD: begin
                src_rd = stage_free;
                take   = stage_free && src_vld;
                if (take) begin
                    load      = 1'b1;
                    load_byte = src_byte;
                    load_last = src_last;
                    if (src_last) state_next = IDLE;
                end
            end
            DROP: begin
                src_rd = 1'b1;
                take   = src_vld;
                if (src_vld && src_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_txmac_clk or negedge i_txmac_arst_n) begin
        if (!i_txmac_arst_n) state <= IDLE;
        else                 state <= state_next;
    end

    // Packet context, checksum accumulation, counters and status pulses
    always_ff @(posedge i_txmac_clk or negedge i_txmac_arst_n) begin
        if (!i_txmac_arst_n) begin
            sel_icmp       <= 1'b0;
            len_q          <= 16'h0000;
            dst_q          <= 32'h0000_0000;
            proto_q        <= 8'h00;
            sum_q          <= 20'h00000;
            calc_cnt       <= 4'd0;
            hdr_idx        <= 5'd0;
            pay_cnt        <= 16'h0000;
            ident_q        <= 16'h0000;
            len_mismatch_q <= 1'b0;
            pkt_dropped_q  <= 1'b0;
`ifndef IPV4_PKT_BUILDER_ICMP_PRIO_EN
            rr_prefer_icmp <= 1'b0;
`endif
        end else begin
            len_mismatch_q <= 1'b0;
            pkt_dropped_q  <= 1'b0;
            case (state)
                ARB: begin
                    sel_icmp      <= pick_icmp;
                    len_q         <= pick_len;
                    dst_q         <= pick_icmp ? i_icmp_dst_ip : i_udp_dst_ip;
                    proto_q       <= pick_icmp ? PROTO_ICMP : PROTO_UDP;
                    sum_q         <= 20'h00000;
                    calc_cnt      <= 4'd0;
                    hdr_idx       <= 5'd0;
                    pay_cnt       <= 16'h0000;
                    pkt_dropped_q <= any_vld && pick_len_bad;
                end
                CALC: begin
                    calc_cnt <= calc_cnt + 4'd1;
                    // Ten additions, then two end-around-carry folds
                    if (calc_cnt < 4'd10)
                        sum_q <= sum_q + {4'h0, word_val};
                    else
                        sum_q <= {4'h0, sum_q[15:0]} + {16'h0000, sum_q[19:16]};
                end
                SEND_HDR: begin
                    if (load) hdr_idx <= hdr_idx + 5'd1;
                end
                SEND_PAYLOAD: begin
                    if (take) begin
                        pay_cnt <= pay_cnt + 16'd1;
                        if (src_last) begin
                            len_mismatch_q <= (pay_cnt + 16'd1) != len_q;
                            ident_q        <= ident_q + 16'd1;
`ifndef IPV4_PKT_BUILDER_ICMP_PRIO_EN
                            rr_prefer_icmp <= !sel_icmp;
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Output stage: reloads in the same cycle it is consumed
    always_ff @(posedge i_txmac_clk or negedge i_txmac_arst_n) begin
        if (!i_txmac_arst_n) begin
            out_vld  <= 1'b0;
            out_byte <= 8'h00;
            out_last <= 1'b0;
        end else if (load) begin
            out_vld  <= 1'b1;
            out_byte <= load_byte;
            out_last <= load_last;
        end else if (i_ipv4_pkt_byte_rd) begin
            out_vld  <= 1'b0;
            out_last <= 1'b0;
        end
    end

    assign o_udp_pkt_byte_rd    = src_rd && !sel_icmp;
    assign o_icmp_pkt_byte_rd   = src_rd && sel_icmp;
    assign o_ipv4_pkt_byte      = out_byte;
    assign o_ipv4_pkt_byte_vld  = out_vld;
    assign o_ipv4_pkt_last_byte = out_last;
    assign o_len_mismatch       = len_mismatch_q;
    assign o_pkt_dropped        = pkt_dropped_q;

endmodule

// File: tb/tb_ipv4_pkt_builder.sv
// ----------------------------------------------------------------------------
// tb_ipv4_pkt_builder
//
// Self-checking bench for ipv4_pkt_builder. Source packets are queued per
// source; the expected output bytes (header from an independent checksum
// model + payload) are pushed into a scoreboard queue in service order and
// popped as the DUT hands bytes downstream.
// ----------------------------------------------------------------------------
module tb_ipv4_pkt_builder;

    typedef struct {
        logic [7:0]  data;
        logic        last;
        logic [15:0] len;
        logic [31:0] dst;
    } beat_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    typedef struct {
        bit          is_icmp;
        int          len_decl;
        int          n_bytes;
        logic [31:0] dst;
        bit          exp_drop;
        bit          exp_mismatch;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  i_udp_pkt_byte;
    logic        i_udp_pkt_byte_vld;
    logic        i_udp_pkt_last_byte;
    logic [15:0] i_udp_pkt_len;
    logic [31:0] i_udp_dst_ip;
    logic        o_udp_pkt_byte_rd;
    logic [7:0]  i_icmp_pkt_byte;
    logic        i_icmp_pkt_byte_vld;
    logic        i_icmp_pkt_last_byte;
    logic [15:0] i_icmp_pkt_len;
    logic [31:0] i_icmp_dst_ip;
    logic        o_icmp_pkt_byte_rd;
    logic [7:0]  o_ipv4_pkt_byte;
    logic        o_ipv4_pkt_byte_vld;
    logic        o_ipv4_pkt_last_byte;
    logic        i_ipv4_pkt_byte_rd;
    logic        o_len_mismatch;
    logic        o_pkt_dropped;

    ipv4_pkt_builder dut (
        .i_txmac_clk          (clk),
        .i_txmac_arst_n       (rst_n),
        .i_udp_pkt_byte       (i_udp_pkt_byte),
        .i_udp_pkt_byte_vld   (i_udp_pkt_byte_vld),
        .i_udp_pkt_last_byte  (i_udp_pkt_last_byte),
        .i_udp_pkt_len        (i_udp_pkt_len),
        .i_udp_dst_ip         (i_udp_dst_ip),
        .o_udp_pkt_byte_rd    (o_udp_pkt_byte_rd),
        .i_icmp_pkt_byte      (i_icmp_pkt_byte),
        .i_icmp_pkt_byte_vld  (i_icmp_pkt_byte_vld),
        .i_icmp_pkt_last_byte (i_icmp_pkt_last_byte),
        .i_icmp_pkt_len       (i_icmp_pkt_len),
        .i_icmp_dst_ip        (i_icmp_dst_ip),
        .o_icmp_pkt_byte_rd   (o_icmp_pkt_byte_rd),
        .o_ipv4_pkt_byte      (o_ipv4_pkt_byte),
        .o_ipv4_pkt_byte_vld  (o_ipv4_pkt_byte_vld),
        .o_ipv4_pkt_last_byte (o_ipv4_pkt_last_byte),
        .i_ipv4_pkt_byte_rd   (i_ipv4_pkt_byte_rd),
        .o_len_mismatch       (o_len_mismatch),
        .o_pkt_dropped        (o_pkt_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    beat_t       udp_q[$];
    beat_t       icmp_q[$];
    exp_t        exp_q[$];
    logic [7:0]  cap_q[$];
    bit          udp_pop;
    bit          icmp_pop;
    bit          rand_mode;
    int          tests;
    int          fails;
    int          rd_cnt;
    int          drop_cnt;
    int          mism_cnt;
    int          out_cnt;
    int          both_rd_cnt;
    logic [15:0] ident_m;
    bit          rr_icmp_next;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Queue one source packet and, if it should be sent, its expected bytes
    task automatic push_pkt(input bit is_icmp, input int len_decl, input int n_bytes,
                            input logic [31:0] dst, input bit sent);
        beat_t       b;
        exp_t        e;
        logic [7:0]  h[20];
        logic [15:0] tot;
        logic [15:0] csum;
        logic [31:0] s;
        logic [7:0]  proto;
        logic [7:0]  pay;
        proto = is_icmp ? 8'h01 : 8'h11;
        tot   = 16'(len_decl + 20);
        h = '{8'h45, 8'h00, tot[15:8], tot[7:0], ident_m[15:8], ident_m[7:0],
              8'h40, 8'h00, 8'd64, proto, 8'h00, 8'h00,
              8'h0A, 8'h00, 8'h00, 8'h01, dst[31:24], dst[23:16], dst[15:8], dst[7:0]};
        s = 32'h0;
        for (int i = 0; i < 10; i++) s = s + {16'h0000, h[2*i], h[2*i+1]};
        while (s[31:16] != 16'h0000) s = {16'h0000, s[15:0]} + {16'h0000, s[31:16]};
        csum  = ~s[15:0];
        h[10] = csum[15:8];
        h[11] = csum[7:0];
        if (sent) begin
            for (int i = 0; i < 20; i++) begin
                e.data = h[i];
                e.last = 1'b0;
                exp_q.push_back(e);
            end
        end
        for (int i = 0; i < n_bytes; i++) begin
            pay    = 8'($urandom);
            b.data = pay;
            b.last = (i == n_bytes - 1);
            b.len  = 16'(len_decl);
            b.dst  = dst;
            if (is_icmp) icmp_q.push_back(b);
            else         udp_q.push_back(b);
            if (sent) begin
                e.data = pay;
                e.last = b.last;
                exp_q.push_back(e);
            end
        end
        if (sent) begin
            ident_m      = ident_m + 16'd1;
            rr_icmp_next = !is_icmp;
        end
    endtask

    task automatic waitIdle(input int budget, input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || udp_q.size() != 0 || icmp_q.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n >= budget) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s_timeout: %0d bytes still expected, needed 0", name, exp_q.size());
            udp_q.delete();
            icmp_q.delete();
            exp_q.delete();
        end
        repeat (4) @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input vec_t v, input string name);
        rd_cnt   = 0;
        drop_cnt = 0;
        mism_cnt = 0;
        out_cnt  = 0;
        push_pkt(v.is_icmp, v.len_decl, v.n_bytes, v.dst, !v.exp_drop);
        waitIdle(6000, name);
        checkOutput({name, "_dropped"},  32'(drop_cnt), 32'(v.exp_drop ? 1 : 0));
        checkOutput({name, "_mismatch"}, 32'(mism_cnt), 32'(v.exp_mismatch ? 1 : 0));
        checkOutput({name, "_rd_bytes"}, 32'(rd_cnt),   32'(v.n_bytes));
        checkOutput({name, "_out_bytes"}, 32'(out_cnt), 32'(v.exp_drop ? 0 : 20 + v.n_bytes));
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, "_vld"},      32'(o_ipv4_pkt_byte_vld),  32'h0);
        checkOutput({name, "_byte"},     32'(o_ipv4_pkt_byte),      32'h0);
        checkOutput({name, "_last"},     32'(o_ipv4_pkt_last_byte), 32'h0);
        checkOutput({name, "_udp_rd"},   32'(o_udp_pkt_byte_rd),    32'h0);
        checkOutput({name, "_icmp_rd"},  32'(o_icmp_pkt_byte_rd),   32'h0);
        checkOutput({name, "_mismatch"}, 32'(o_len_mismatch),       32'h0);
        checkOutput({name, "_dropped"},  32'(o_pkt_dropped),        32'h0);
    endtask

    // Per-cycle engine: drive sources and downstream rd at negedge, then
    // sample handshakes and outputs 1 ns later, well before the next posedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (udp_pop && udp_q.size() > 0)   void'(udp_q.pop_front());
            if (icmp_pop && icmp_q.size() > 0) void'(icmp_q.pop_front());
            udp_pop  = 1'b0;
            icmp_pop = 1'b0;
            if (udp_q.size() > 0 && !(rand_mode && $urandom_range(0, 3) == 0)) begin
                i_udp_pkt_byte_vld  = 1'b1;
                i_udp_pkt_byte      = udp_q[0].data;
                i_udp_pkt_last_byte = udp_q[0].last;
                i_udp_pkt_len       = udp_q[0].len;
                i_udp_dst_ip        = udp_q[0].dst;
            end else begin
                i_udp_pkt_byte_vld  = 1'b0;
                i_udp_pkt_byte      = 8'h00;
                i_udp_pkt_last_byte = 1'b0;
            end
            if (icmp_q.size() > 0 && !(rand_mode && $urandom_range(0, 3) == 0)) begin
                i_icmp_pkt_byte_vld  = 1'b1;
                i_icmp_pkt_byte      = icmp_q[0].data;
                i_icmp_pkt_last_byte = icmp_q[0].last;
                i_icmp_pkt_len       = icmp_q[0].len;
                i_icmp_dst_ip        = icmp_q[0].dst;
            end else begin
                i_icmp_pkt_byte_vld  = 1'b0;
                i_icmp_pkt_byte      = 8'h00;
                i_icmp_pkt_last_byte = 1'b0;
            end
            i_ipv4_pkt_byte_rd = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (o_udp_pkt_byte_rd && i_udp_pkt_byte_vld) begin
                udp_pop = 1'b1;
                rd_cnt++;
            end
            if (o_icmp_pkt_byte_rd && i_icmp_pkt_byte_vld) begin
                icmp_pop = 1'b1;
                rd_cnt++;
            end
            if (o_udp_pkt_byte_rd && o_icmp_pkt_byte_rd) both_rd_cnt++;
            if (o_ipv4_pkt_byte_vld && i_ipv4_pkt_byte_rd) begin
                out_cnt++;
                cap_q.push_back(o_ipv4_pkt_byte);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_out: got byte 0x%02h, expected no output", o_ipv4_pkt_byte);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("out_byte", 32'(o_ipv4_pkt_byte),      32'(e.data));
                    checkOutput("out_last", 32'(o_ipv4_pkt_last_byte), 32'(e.last));
                end
            end
            if (o_pkt_dropped)  drop_cnt++;
            if (o_len_mismatch) mism_cnt++;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t       vecs[10];
        vec_t       v;
        logic [7:0] golden[20];
        int         n;

        tests = 0; fails = 0; rd_cnt = 0; drop_cnt = 0; mism_cnt = 0; out_cnt = 0;
        both_rd_cnt = 0; ident_m = 16'h0000; rr_icmp_next = 1'b0;
        rand_mode = 1'b0; udp_pop = 1'b0; icmp_pop = 1'b0;
        i_udp_pkt_byte = 8'h00;  i_udp_pkt_byte_vld = 1'b0;  i_udp_pkt_last_byte = 1'b0;
        i_udp_pkt_len = 16'h0;   i_udp_dst_ip = 32'h0;
        i_icmp_pkt_byte = 8'h00; i_icmp_pkt_byte_vld = 1'b0; i_icmp_pkt_last_byte = 1'b0;
        i_icmp_pkt_len = 16'h0;  i_icmp_dst_ip = 32'h0;
        i_ipv4_pkt_byte_rd = 1'b1;
        rst_n = 1'b0;

        golden = '{8'h45, 8'h00, 8'h00, 8'h1C, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                   8'h26, 8'hCF, 8'h0A, 8'h00, 8'h00, 8'h01, 8'h0A, 8'h00, 8'h00, 8'h02};

        //          icmp  len   n     dst            drop  mism
        vecs[0] = '{1'b0, 8,    8,    32'h0A000002, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8,    8,    32'h0A000002, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 20,   20,   32'hC0A80105, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1500, 1500, 32'h0A000003, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 0,    4,    32'h0A000004, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 10,   7,    32'h0A000005, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1480, 1480, 32'hC0A80106, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1481, 3,    32'hC0A80107, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 1,    1,    32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 5,    9,    32'h0A000009, 1'b0, 1'b1};

        repeat (3) @(posedge clk);
        #2;
        checkResetOutputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        // Table-driven single packets
        for (int k = 0; k < 10; k++) begin
            cap_q.delete();
            applyStimulus(vecs[k], $sformatf("vec%0d", k));
            if (k == 0) begin
                checkOutput("vec0_cap_size", 32'(cap_q.size()), 32'd28);
                for (int i = 0; i < 20 && i < cap_q.size(); i++)
                    checkOutput($sformatf("vec0_hdr%0d", i), 32'(cap_q[i]), 32'(golden[i]));
            end
        end

        // Both sources loaded with three packets each
        rd_cnt = 0; drop_cnt = 0; mism_cnt = 0; out_cnt = 0;
`ifdef IPV4_PKT_BUILDER_ICMP_PRIO_EN
        for (int k = 0; k < 3; k++) push_pkt(1'b1, 4, 4, 32'hC0A80200 + 32'(k), 1'b1);
        for (int k = 0; k < 3; k++) push_pkt(1'b0, 6, 6, 32'h0A000100 + 32'(k), 1'b1);
`else
        for (int k = 0; k < 6; k++) begin
            if (rr_icmp_next) push_pkt(1'b1, 4, 4, 32'hC0A80200 + 32'(k), 1'b1);
            else              push_pkt(1'b0, 6, 6, 32'h0A000100 + 32'(k), 1'b1);
        end
`endif
        waitIdle(2000, "arb");
        checkOutput("arb_out_bytes", 32'(out_cnt),  32'd150);
        checkOutput("arb_rd_bytes",  32'(rd_cnt),   32'd30);
        checkOutput("arb_dropped",   32'(drop_cnt), 32'd0);

        // Random downstream stalls and source gaps on 64-byte packets
        rand_mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            v = '{bit'(k % 2), 64, 64, 32'h0A0A0000 + 32'(k), 1'b0, 1'b0};
            applyStimulus(v, $sformatf("rand%0d", k));
        end
        rand_mode = 1'b0;

        // Reset asserted in the middle of a header
        rd_cnt = 0; drop_cnt = 0; mism_cnt = 0; out_cnt = 0;
        push_pkt(1'b0, 8, 8, 32'h0A0000FE, 1'b1);
        n = 0;
        while (out_cnt < 5 && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        checkOutput("midreset_reached_hdr", 32'(out_cnt >= 5), 32'd1);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("midreset");
        udp_q.delete();
        icmp_q.delete();
        exp_q.delete();
        udp_pop = 1'b0;
        icmp_pop = 1'b0;
        ident_m = 16'h0000;
        rr_icmp_next = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        v = '{1'b0, 8, 8, 32'h0A000002, 1'b0, 1'b0};
        cap_q.delete();
        applyStimulus(v, "restart");
        for (int i = 0; i < 20 && i < cap_q.size(); i++)
            checkOutput($sformatf("restart_hdr%0d", i), 32'(cap_q[i]), 32'(golden[i]));

        checkOutput("single_source_rd", 32'(both_rd_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
